rat_history_buf: RTL and testbench

- Retire/recovery-side partner of the PRF rename map. Produces the reclaim and restore packets that the PRF consumes.
- Records every rename allocation (gpr, new pdst, old pdst) in program order in a circular history buffer.
- On retire, emits a reclaim packet that frees the overwritten old pdst.
- On flush, walks younger entries youngest-first and emits one restore packet per cycle, which rolls the map back and frees the squashed pdst.

---
 rtl/rat_history_buf_pkg.sv | 42 ++++
 rtl/rat_history_buf.sv | 167 ++++++++++++++++
 tb/tb_rat_history_buf.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rat_history_buf_pkg.sv
// Shared rename-side types: history entries, walk states and the packets
// the PRF consumes on retire (reclaim) and on flush recovery (restore).
package rat_history_buf_pkg;

  localparam int GPR_W          = 5;
  localparam int PRF_W          = 7;
  localparam int SIMID_W        = 16;
  localparam int HB_NUM_ENTRIES = 16;
  localparam int HB_DEF_IDX_W   = $clog2(HB_NUM_ENTRIES);

  typedef logic [GPR_W-1:0]        t_gpr_id;
  typedef logic [PRF_W-1:0]        t_prf_id;
  typedef logic [SIMID_W-1:0]      t_simid;
  typedef logic [HB_DEF_IDX_W-1:0] t_hb_id;
  typedef logic [HB_DEF_IDX_W:0]   t_hb_ptr;

  typedef struct packed {
    t_gpr_id gpr;
    t_prf_id pdst;
    t_prf_id pdst_old;
    t_simid  simid;
  } t_hb_entry;

  typedef enum logic {
    HB_IDLE = 1'b0,
    HB_WALK = 1'b1
  } t_hb_walk_state;

  typedef struct packed {
    logic    valid;
    t_prf_id prfid;
    t_simid  simid;
  } t_rat_reclaim_pkt;

  typedef struct packed {
    logic    valid;
    t_gpr_id gpr;
    t_prf_id prfid;
    t_simid  simid;
  } t_rat_restore_pkt;

endpackage

// File: rtl/rat_history_buf.sv
// Rename history buffer: records every rename allocation in program order,
// frees the overwritten mapping on retire, and on flush walks the squashed
// entries youngest-first emitting one map-restore packet per cycle.
//
// state   | meaning
// --------+------------------------------------------------------------
// HB_IDLE | normal operation; allocs, retires and flush requests accepted
// HB_WALK | one squashed entry popped from the tail per cycle until stop
module rat_history_buf
  import rat_history_buf_pkg::*;
#(
  parameter int NUM_ENTRIES = HB_NUM_ENTRIES,
  parameter int HB_IDX_W    = $clog2(NUM_ENTRIES)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                alloc_rn1,
  input  t_gpr_id             alloc_gpr_rn1,
  input  t_prf_id             alloc_pdst_rn1,
  input  t_prf_id             alloc_pdst_old_rn1,
  input  t_simid              alloc_simid_rn1,
  output logic [HB_IDX_W-1:0] alloc_hbid_rn1,
  output logic                hist_full,
  output logic                walk_busy,
  input  logic                retire_rb0,
  input  logic                flush_rb0,
  input  logic                flush_all_rb0,
  input  logic [HB_IDX_W-1:0] flush_hbid_rb0,
  output t_rat_reclaim_pkt    rat_reclaim_pkt_rb1,
  output t_rat_restore_pkt    rat_restore_pkt_rbx
);

  localparam int              PTR_W    = HB_IDX_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(NUM_ENTRIES);

  t_hb_entry           r_mem [NUM_ENTRIES];
  logic [PTR_W-1:0]    r_head;
  logic [PTR_W-1:0]    r_tail;
  logic [PTR_W-1:0]    r_stop;
  t_hb_walk_state      r_state;
  t_hb_walk_state      w_state_nxt;

  logic [PTR_W-1:0]    w_count;
  logic [PTR_W-1:0]    w_head_nxt;
  logic [PTR_W-1:0]    w_tail_alloc;
  logic [PTR_W-1:0]    w_tail_dec;
  logic [PTR_W-1:0]    w_tail_nxt;
  logic [PTR_W-1:0]    w_flush_stop;
  logic [HB_IDX_W-1:0] w_stop_idx;
  logic [HB_IDX_W-1:0] w_back_dist;
  logic                w_flush_go;
  t_hb_entry           w_head_ent;
  t_hb_entry           w_walk_ent;
  logic                w_unused_pdst;

  // Occupancy uses the wrap bit so full and empty are distinguishable.
  assign w_count        = r_tail - r_head;
  assign hist_full      = (w_count == PTR_FULL);
  assign walk_busy      = (r_state == HB_WALK);
  assign alloc_hbid_rn1 = r_tail[HB_IDX_W-1:0];

  assign w_head_nxt   = r_head + PTR_W'(retire_rb0);
  assign w_tail_alloc = r_tail + PTR_W'(alloc_rn1);
  assign w_tail_dec   = r_tail - PTR_ONE;

  assign w_head_ent = r_mem[r_head[HB_IDX_W-1:0]];
  assign w_walk_ent = r_mem[w_tail_dec[HB_IDX_W-1:0]];

  // The new pdst is kept for debug visibility only; the PRF frees squashed
  // pdsts through its own current map, so nothing downstream reads it.
  assign w_unused_pdst = ^{w_head_ent.pdst, w_walk_ent.pdst};

  // Stop pointer is rebuilt backwards from the (post-alloc) tail: the
  // distance tail - stop is below NUM_ENTRIES, so the low index bits are
  // enough to recover the full wrap-extended pointer even when full.
  assign w_stop_idx   = flush_hbid_rb0 + HB_IDX_W'(1);
  assign w_back_dist  = w_tail_alloc[HB_IDX_W-1:0] - w_stop_idx;
  assign w_flush_stop = flush_all_rb0 ? w_head_nxt
                                      : (w_tail_alloc - {1'b0, w_back_dist});
  assign w_flush_go   = flush_rb0 && (r_state == HB_IDLE)
                        && (w_flush_stop != w_tail_alloc);

  // Next-state and tail selection for the two-state walk machine.
  always_comb begin
    w_state_nxt = r_state;
    w_tail_nxt  = w_tail_alloc;
    case (r_state)
      HB_IDLE: begin
        if (w_flush_go) begin
          w_state_nxt = HB_WALK;
        end
      end
      HB_WALK: begin
        w_tail_nxt = w_tail_dec;
        if (w_tail_dec == r_stop) begin
          w_state_nxt = HB_IDLE;
        end
      end
      default: begin
        w_state_nxt = HB_IDLE;
      end
    endcase
  end

  // Pointers, walk state and captured stop pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_stop  <= '0;
      r_state <= HB_IDLE;
    end else begin
      r_head  <= w_head_nxt;
      r_tail  <= w_tail_nxt;
      r_state <= w_state_nxt;
      if (w_flush_go) begin
        r_stop <= w_flush_stop;
      end
    end
  end

  // Entry storage is written at the tail and deliberately left unreset.
  always_ff @(posedge clk) begin
    if (alloc_rn1) begin
      r_mem[r_tail[HB_IDX_W-1:0]] <= '{gpr:      alloc_gpr_rn1,
                                       pdst:     alloc_pdst_rn1,
                                       pdst_old: alloc_pdst_old_rn1,
                                       simid:    alloc_simid_rn1};
    end
  end

  // Registered reclaim (retire) and restore (walk step) packets.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rat_reclaim_pkt_rb1 <= '0;
      rat_restore_pkt_rbx <= '0;
    end else begin
      rat_reclaim_pkt_rb1.valid <= retire_rb0;
      rat_reclaim_pkt_rb1.prfid <= w_head_ent.pdst_old;
      rat_reclaim_pkt_rb1.simid <= w_head_ent.simid;
      rat_restore_pkt_rbx.valid <= (r_state == HB_WALK);
      rat_restore_pkt_rbx.gpr   <= w_walk_ent.gpr;
      rat_restore_pkt_rbx.prfid <= w_walk_ent.pdst_old;
      rat_restore_pkt_rbx.simid <= w_walk_ent.simid;
    end
  end

`ifndef SYNTHESIS
  logic [HB_IDX_W-1:0] w_hbid_ofs;
  assign w_hbid_ofs = flush_hbid_rb0 - r_head[HB_IDX_W-1:0];

  a_alloc_full: assert property (@(posedge clk) disable iff (!reset_n)
    (alloc_rn1 && hist_full) |-> retire_rb0);
  a_alloc_walk: assert property (@(posedge clk) disable iff (!reset_n)
    alloc_rn1 |-> !walk_busy);
  a_retire_empty: assert property (@(posedge clk) disable iff (!reset_n)
    retire_rb0 |-> (w_count != '0));
  a_flush_walk: assert property (@(posedge clk) disable iff (!reset_n)
    flush_rb0 |-> !walk_busy);
  a_flush_range: assert property (@(posedge clk) disable iff (!reset_n)
    (flush_rb0 && !flush_all_rb0) |-> ((w_count != '0) && ({1'b0, w_hbid_ofs} < w_count)));
  a_retire_walked: assert property (@(posedge clk) disable iff (!reset_n)
    (retire_rb0 && walk_busy) |-> (r_head != r_stop));
`endif

endmodule

// File: tb/tb_rat_history_buf.sv
// Bench for the rename history buffer: directed scenarios plus a random
// traffic run, all compared against a queue-based model of the history.
module tb_rat_history_buf;
  import rat_history_buf_pkg::*;

  localparam int N  = 16;
  localparam int IW = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             alloc_rn1;
  t_gpr_id          alloc_gpr_rn1;
  t_prf_id          alloc_pdst_rn1;
  t_prf_id          alloc_pdst_old_rn1;
  t_simid           alloc_simid_rn1;
  logic [IW-1:0]    alloc_hbid_rn1;
  logic             hist_full;
  logic             walk_busy;
  logic             retire_rb0;
  logic             flush_rb0;
  logic             flush_all_rb0;
  logic [IW-1:0]    flush_hbid_rb0;
  t_rat_reclaim_pkt rat_reclaim_pkt_rb1;
  t_rat_restore_pkt rat_restore_pkt_rbx;

  always #5 clk = ~clk;

  rat_history_buf #(.NUM_ENTRIES(N)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .alloc_rn1          (alloc_rn1),
    .alloc_gpr_rn1      (alloc_gpr_rn1),
    .alloc_pdst_rn1     (alloc_pdst_rn1),
    .alloc_pdst_old_rn1 (alloc_pdst_old_rn1),
    .alloc_simid_rn1    (alloc_simid_rn1),
    .alloc_hbid_rn1     (alloc_hbid_rn1),
    .hist_full          (hist_full),
    .walk_busy          (walk_busy),
    .retire_rb0         (retire_rb0),
    .flush_rb0          (flush_rb0),
    .flush_all_rb0      (flush_all_rb0),
    .flush_hbid_rb0     (flush_hbid_rb0),
    .rat_reclaim_pkt_rb1(rat_reclaim_pkt_rb1),
    .rat_restore_pkt_rbx(rat_restore_pkt_rbx)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: live (surviving) entries oldest-first, entries still
  // to be restored youngest-first, and the index of the oldest live entry.
  t_hb_entry m_live[$];
  t_hb_entry m_walk[$];
  int        m_head;
  bit        m_walking;
  int        sim_ctr;
  bit        e_rcl_v;
  t_hb_entry e_rcl;
  bit        e_rst_v;
  t_hb_entry e_rst;

  function automatic int exp_hbid();
    return (m_head + m_live.size() + m_walk.size()) % N;
  endfunction

  function automatic bit exp_full();
    return (m_live.size() + m_walk.size()) == N;
  endfunction

  // Drive one cycle of inputs, advance the model, sample #1 after the edge.
  task automatic cyc(input bit a, input t_gpr_id g, input t_prf_id p, input t_prf_id po,
                     input bit r, input bit f, input bit fa, input int fh);
    t_hb_entry ent;
    int        n_sq;
    int        keep;
    alloc_rn1          = a;
    alloc_gpr_rn1      = g;
    alloc_pdst_rn1     = p;
    alloc_pdst_old_rn1 = po;
    alloc_simid_rn1    = t_simid'(sim_ctr);
    retire_rb0         = r;
    flush_rb0          = f;
    flush_all_rb0      = fa;
    flush_hbid_rb0     = IW'(fh % N);
    ent = '{gpr: g, pdst: p, pdst_old: po, simid: t_simid'(sim_ctr)};
    if (a) sim_ctr++;
    n_sq = 0;
    if (f) begin
      keep = fa ? int'(r) : ((((fh - m_head) % N) + N) % N) + 1;
      n_sq = m_live.size() + int'(a) - keep;
    end
    e_rst_v = 1'b0;
    if (m_walking) begin
      e_rst_v = 1'b1;
      e_rst   = m_walk.pop_front();
      if (m_walk.size() == 0) m_walking = 1'b0;
    end
    e_rcl_v = r;
    if (r && m_live.size() > 0) begin
      e_rcl  = m_live.pop_front();
      m_head = (m_head + 1) % N;
    end
    if (a) m_live.push_back(ent);
    for (int i = 0; i < n_sq; i++) m_walk.push_back(m_live.pop_back());
    if (n_sq > 0) m_walking = 1'b1;
    @(posedge clk);
    #1;
    alloc_rn1     = 1'b0;
    retire_rb0    = 1'b0;
    flush_rb0     = 1'b0;
    flush_all_rb0 = 1'b0;
  endtask

  task automatic idle();
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic alloc_rand();
    cyc(1'b1, t_gpr_id'($urandom), t_prf_id'($urandom), t_prf_id'($urandom),
        1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic do_reset();
    reset_n            = 1'b0;
    alloc_rn1          = 1'b0;
    alloc_gpr_rn1      = '0;
    alloc_pdst_rn1     = '0;
    alloc_pdst_old_rn1 = '0;
    alloc_simid_rn1    = '0;
    retire_rb0         = 1'b0;
    flush_rb0          = 1'b0;
    flush_all_rb0      = 1'b0;
    flush_hbid_rb0     = '0;
    m_live.delete();
    m_walk.delete();
    m_head    = 0;
    m_walking = 1'b0;
    e_rcl_v   = 1'b0;
    e_rst_v   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (rat_reclaim_pkt_rb1.valid !== 1'b0 || rat_restore_pkt_rbx.valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valids got rcl=%b rst=%b exp 0/0",
               rat_reclaim_pkt_rb1.valid, rat_restore_pkt_rbx.valid);
    end
    checks++;
    if (walk_busy !== 1'b0 || hist_full !== 1'b0 || alloc_hbid_rn1 !== '0) begin
      errors++;
      $display("FAIL reset_state got busy=%b full=%b hbid=%0d exp 0/0/0",
               walk_busy, hist_full, alloc_hbid_rn1);
    end
  endtask

  task automatic test_retire_reclaim();
    t_prf_id exp_p[3];
    exp_p = '{t_prf_id'(5), t_prf_id'(6), t_prf_id'(32)};
    cyc(1'b1, 5'd5, 7'd32, 7'd5,  1'b0, 1'b0, 1'b0, 0);
    cyc(1'b1, 5'd6, 7'd33, 7'd6,  1'b0, 1'b0, 1'b0, 0);
    cyc(1'b1, 5'd5, 7'd34, 7'd32, 1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0, 0);
      checks++;
      if (rat_reclaim_pkt_rb1.valid !== 1'b1 || rat_reclaim_pkt_rb1.prfid !== exp_p[i]
          || rat_reclaim_pkt_rb1.simid !== e_rcl.simid || hist_full !== 1'b0) begin
        errors++;
        $display("FAIL reclaim%0d got v=%b p=%0d sim=%0d full=%b exp v=1 p=%0d sim=%0d full=0",
                 i, rat_reclaim_pkt_rb1.valid, rat_reclaim_pkt_rb1.prfid,
                 rat_reclaim_pkt_rb1.simid, hist_full, exp_p[i], e_rcl.simid);
      end
    end
    idle();
    checks++;
    if (rat_reclaim_pkt_rb1.valid !== 1'b0) begin
      errors++;
      $display("FAIL reclaim_idle got v=%b exp 0", rat_reclaim_pkt_rb1.valid);
    end
  endtask

  task automatic test_full_wrap();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (alloc_hbid_rn1 !== IW'(exp_hbid())) begin
        errors++;
        $display("FAIL fill_hbid%0d got %0d exp %0d", i, alloc_hbid_rn1, exp_hbid());
      end
      alloc_rand();
      if (i == N - 2) begin
        checks++;
        if (hist_full !== 1'b0) begin
          errors++;
          $display("FAIL full_early got %b exp 0", hist_full);
        end
      end
    end
    checks++;
    if (hist_full !== 1'b1) begin
      errors++;
      $display("FAIL full_set got %b exp 1", hist_full);
    end
    cyc(1'b1, t_gpr_id'($urandom), t_prf_id'($urandom), t_prf_id'($urandom),
        1'b1, 1'b0, 1'b0, 0);
    checks++;
    if (hist_full !== 1'b1 || rat_reclaim_pkt_rb1.valid !== 1'b1
        || rat_reclaim_pkt_rb1.prfid !== e_rcl.pdst_old) begin
      errors++;
      $display("FAIL full_alloc_retire got full=%b v=%b p=%0d exp full=1 v=1 p=%0d",
               hist_full, rat_reclaim_pkt_rb1.valid, rat_reclaim_pkt_rb1.prfid, e_rcl.pdst_old);
    end
    cyc(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0, 0);
    checks++;
    if (hist_full !== 1'b0) begin
      errors++;
      $display("FAIL full_clear got %b exp 0", hist_full);
    end
    checks++;
    if (alloc_hbid_rn1 !== IW'(exp_hbid())) begin
      errors++;
      $display("FAIL refill_hbid got %0d exp %0d", alloc_hbid_rn1, exp_hbid());
    end
    alloc_rand();
    checks++;
    if (hist_full !== 1'b1) begin
      errors++;
      $display("FAIL refull got %b exp 1", hist_full);
    end
    for (int i = 0; i < N; i++) begin
      cyc(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0, 0);
      checks++;
      if (rat_reclaim_pkt_rb1.valid !== 1'b1 || rat_reclaim_pkt_rb1.prfid !== e_rcl.pdst_old
          || rat_reclaim_pkt_rb1.simid !== e_rcl.simid) begin
        errors++;
        $display("FAIL drain%0d got v=%b p=%0d sim=%0d exp p=%0d sim=%0d", i,
                 rat_reclaim_pkt_rb1.valid, rat_reclaim_pkt_rb1.prfid,
                 rat_reclaim_pkt_rb1.simid, e_rcl.pdst_old, e_rcl.simid);
      end
    end
  endtask

  task automatic test_flush_partial();
    t_hb_entry exp3;
    t_hb_entry exp2;
    do_reset();
    for (int i = 0; i < 4; i++) alloc_rand();
    exp3 = m_live[3];
    exp2 = m_live[2];
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0, 1);
    checks++;
    if (walk_busy !== 1'b1 || rat_restore_pkt_rbx.valid !== 1'b0) begin
      errors++;
      $display("FAIL pflush_enter got busy=%b rst=%b exp 1/0", walk_busy, rat_restore_pkt_rbx.valid);
    end
    idle();
    checks++;
    if (rat_restore_pkt_rbx.valid !== 1'b1 || rat_restore_pkt_rbx.gpr !== exp3.gpr
        || rat_restore_pkt_rbx.prfid !== exp3.pdst_old || walk_busy !== 1'b1) begin
      errors++;
      $display("FAIL pflush_rst3 got v=%b g=%0d p=%0d busy=%b exp v=1 g=%0d p=%0d busy=1",
               rat_restore_pkt_rbx.valid, rat_restore_pkt_rbx.gpr, rat_restore_pkt_rbx.prfid,
               walk_busy, exp3.gpr, exp3.pdst_old);
    end
    idle();
    checks++;
    if (rat_restore_pkt_rbx.valid !== 1'b1 || rat_restore_pkt_rbx.gpr !== exp2.gpr
        || rat_restore_pkt_rbx.prfid !== exp2.pdst_old || walk_busy !== 1'b0) begin
      errors++;
      $display("FAIL pflush_rst2 got v=%b g=%0d p=%0d busy=%b exp v=1 g=%0d p=%0d busy=0",
               rat_restore_pkt_rbx.valid, rat_restore_pkt_rbx.gpr, rat_restore_pkt_rbx.prfid,
               walk_busy, exp2.gpr, exp2.pdst_old);
    end
    checks++;
    if (alloc_hbid_rn1 !== IW'(2)) begin
      errors++;
      $display("FAIL pflush_tail got %0d exp 2", alloc_hbid_rn1);
    end
    idle();
    checks++;
    if (rat_restore_pkt_rbx.valid !== 1'b0) begin
      errors++;
      $display("FAIL pflush_end got v=%b exp 0", rat_restore_pkt_rbx.valid);
    end
  endtask

  task automatic test_flush_all();
    do_reset();
    cyc(1'b1, 5'd5, 7'd40, 7'd5, 1'b0, 1'b0, 1'b0, 0);
    cyc(1'b1, 5'd7, 7'd41, 7'd7, 1'b0, 1'b0, 1'b0, 0);
    cyc(1'b1, 5'd5, 7'd42, 7'd40, 1'b0, 1'b0, 1'b0, 0);
    cyc(1'b1, 5'd9, 7'd43, 7'd9, 1'b0, 1'b0, 1'b0, 0);
    cyc(1'b1, 5'd3, 7'd44, 7'd3, 1'b0, 1'b0, 1'b0, 0);
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b1, 0);
    for (int i = 0; i < 5; i++) begin
      idle();
      checks++;
      if (rat_restore_pkt_rbx.valid !== 1'b1 || rat_restore_pkt_rbx.gpr !== e_rst.gpr
          || rat_restore_pkt_rbx.prfid !== e_rst.pdst_old || rat_restore_pkt_rbx.simid !== e_rst.simid) begin
        errors++;
        $display("FAIL fall_rst%0d got v=%b g=%0d p=%0d exp g=%0d p=%0d", i,
                 rat_restore_pkt_rbx.valid, rat_restore_pkt_rbx.gpr, rat_restore_pkt_rbx.prfid,
                 e_rst.gpr, e_rst.pdst_old);
      end
    end
    checks++;
    if (rat_restore_pkt_rbx.gpr !== 5'd5 || rat_restore_pkt_rbx.prfid !== 7'd5) begin
      errors++;
      $display("FAIL fall_last got g=%0d p=%0d exp g=5 p=5",
               rat_restore_pkt_rbx.gpr, rat_restore_pkt_rbx.prfid);
    end
    idle();
    checks++;
    if (rat_restore_pkt_rbx.valid !== 1'b0 || walk_busy !== 1'b0 || alloc_hbid_rn1 !== IW'(0)) begin
      errors++;
      $display("FAIL fall_empty got v=%b busy=%b hbid=%0d exp 0/0/0",
               rat_restore_pkt_rbx.valid, walk_busy, alloc_hbid_rn1);
    end
  endtask

  task automatic test_no_walk_and_retire_in_walk();
    for (int i = 0; i < 3; i++) alloc_rand();
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0, m_head + 2);
    checks++;
    if (walk_busy !== 1'b0) begin
      errors++;
      $display("FAIL nowalk_busy got %b exp 0", walk_busy);
    end
    idle();
    checks++;
    if (rat_restore_pkt_rbx.valid !== 1'b0 || walk_busy !== 1'b0) begin
      errors++;
      $display("FAIL nowalk_rst got v=%b busy=%b exp 0/0", rat_restore_pkt_rbx.valid, walk_busy);
    end
    alloc_rand();
    alloc_rand();
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0, m_head + 1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, '0, '0, '0, (i < 2), 1'b0, 1'b0, 0);
      checks++;
      if (rat_restore_pkt_rbx.valid !== 1'b1 || rat_restore_pkt_rbx.prfid !== e_rst.pdst_old
          || rat_restore_pkt_rbx.gpr !== e_rst.gpr) begin
        errors++;
        $display("FAIL wr_rst%0d got v=%b g=%0d p=%0d exp g=%0d p=%0d", i,
                 rat_restore_pkt_rbx.valid, rat_restore_pkt_rbx.gpr,
                 rat_restore_pkt_rbx.prfid, e_rst.gpr, e_rst.pdst_old);
      end
      checks++;
      if (rat_reclaim_pkt_rb1.valid !== e_rcl_v
          || (e_rcl_v && rat_reclaim_pkt_rb1.prfid !== e_rcl.pdst_old)) begin
        errors++;
        $display("FAIL wr_rcl%0d got v=%b p=%0d exp v=%b p=%0d", i,
                 rat_reclaim_pkt_rb1.valid, rat_reclaim_pkt_rb1.prfid, e_rcl_v, e_rcl.pdst_old);
      end
    end
  endtask

  task automatic test_reset_mid_walk();
    do_reset();
    for (int i = 0; i < 4; i++) alloc_rand();
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b1, 0);
    idle();
    checks++;
    if (rat_restore_pkt_rbx.valid !== 1'b1 || rat_restore_pkt_rbx.prfid !== e_rst.pdst_old) begin
      errors++;
      $display("FAIL rmw_first got v=%b p=%0d exp v=1 p=%0d",
               rat_restore_pkt_rbx.valid, rat_restore_pkt_rbx.prfid, e_rst.pdst_old);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (rat_restore_pkt_rbx.valid !== 1'b0 || walk_busy !== 1'b0 || hist_full !== 1'b0
        || alloc_hbid_rn1 !== '0) begin
      errors++;
      $display("FAIL rmw_reset got v=%b busy=%b full=%b hbid=%0d exp 0/0/0/0",
               rat_restore_pkt_rbx.valid, walk_busy, hist_full, alloc_hbid_rn1);
    end
    do_reset();
    for (int i = 0; i < 3; i++) begin
      idle();
      checks++;
      if (rat_restore_pkt_rbx.valid !== 1'b0 || walk_busy !== 1'b0) begin
        errors++;
        $display("FAIL rmw_after%0d got v=%b busy=%b exp 0/0", i, rat_restore_pkt_rbx.valid, walk_busy);
      end
    end
  endtask

  task automatic test_random();
    bit a, r, f, fa;
    int fh, live, tot;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      live = m_live.size();
      tot  = live + m_walk.size();
      r  = (live > 0) && ($urandom_range(0, 2) != 0);
      a  = !m_walking && (tot < N || r) && ($urandom_range(0, 3) != 0);
      f  = 1'b0;
      fa = 1'b0;
      fh = 0;
      if (!m_walking && $urandom_range(0, 11) == 0) begin
        f  = 1'b1;
        a  = 1'b0;
        fa = ($urandom_range(0, 3) == 0);
        if (!fa) begin
          if (live == 0) f = 1'b0;
          else fh = m_head + int'($urandom_range(0, live - 1));
        end
      end
      cyc(a, t_gpr_id'($urandom), t_prf_id'($urandom), t_prf_id'($urandom), r, f, fa, fh);
      checks++;
      if (rat_reclaim_pkt_rb1.valid !== e_rcl_v || (e_rcl_v &&
          (rat_reclaim_pkt_rb1.prfid !== e_rcl.pdst_old || rat_reclaim_pkt_rb1.simid !== e_rcl.simid))) begin
        errors++;
        $display("FAIL rnd_rcl c=%0d got v=%b p=%0d exp v=%b p=%0d", c,
                 rat_reclaim_pkt_rb1.valid, rat_reclaim_pkt_rb1.prfid, e_rcl_v, e_rcl.pdst_old);
      end
      checks++;
      if (rat_restore_pkt_rbx.valid !== e_rst_v || (e_rst_v &&
          (rat_restore_pkt_rbx.gpr !== e_rst.gpr || rat_restore_pkt_rbx.prfid !== e_rst.pdst_old
           || rat_restore_pkt_rbx.simid !== e_rst.simid))) begin
        errors++;
        $display("FAIL rnd_rst c=%0d got v=%b g=%0d p=%0d exp v=%b g=%0d p=%0d", c,
                 rat_restore_pkt_rbx.valid, rat_restore_pkt_rbx.gpr, rat_restore_pkt_rbx.prfid,
                 e_rst_v, e_rst.gpr, e_rst.pdst_old);
      end
      checks++;
      if (walk_busy !== m_walking || hist_full !== exp_full() || alloc_hbid_rn1 !== IW'(exp_hbid())) begin
        errors++;
        $display("FAIL rnd_state c=%0d got busy=%b full=%b hbid=%0d exp %b/%b/%0d", c,
                 walk_busy, hist_full, alloc_hbid_rn1, m_walking, exp_full(), exp_hbid());
      end
    end
  endtask

  initial begin
    sim_ctr = 1;
    test_reset();
    test_retire_reclaim();
    test_full_wrap();
    test_flush_partial();
    test_flush_all();
    test_no_walk_and_retire_in_walk();
    test_reset_mid_walk();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
